// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared types and helpers for the audio sample path. Holds the
//               sequencer state encoding, the default sample width and the
//               mid-scale helper used for reset values.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

  // Default sample width shared by the ADC, the filter and the DAC
  localparam int AUDIO_N = 10;

  // Sample sequencer states: wait for a conversion, let the filter settle,
  // then write the filter result into the FIFO.
  typedef enum logic [1:0] {
    SP_IDLE   = 2'd0,
    SP_SETTLE = 2'd1,
    SP_WRITE  = 2'd2
  } sp_state_t;

  // Mid-scale code of an unsigned n-bit sample, 2^(n-1)
  function automatic int unsigned midscale(input int unsigned n);
    return 32'd1 << (n - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : DEPTH x N sample FIFO with an explicit occupancy counter.
//               The caller qualifies wr_i/rd_i against full/empty; a write
//               while full is legal only together with a read.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
  parameter int N     = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_i,
  input  logic                       rd_i,
  input  logic [N-1:0]               wdata_i,
  output logic [N-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int c_pw = $clog2(DEPTH);
  localparam int c_lw = $clog2(DEPTH + 1);
  localparam logic [c_lw-1:0] c_depth = c_lw'(DEPTH);

  logic [N-1:0]    mem_q [DEPTH];
  logic [c_pw-1:0] wr_ptr_q;
  logic [c_pw-1:0] rd_ptr_q;
  logic [c_lw-1:0] level_q;

  // Storage array; no reset needed since cleared pointers make old data unreachable
  always_ff @(posedge clk) begin
    if (wr_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally; level counts +1 on write, -1 on read, 0 on both
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_i && !rd_i) begin
        level_q <= level_q + 1'b1;
      end else if (rd_i && !wr_i) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == c_depth);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/sample_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : sample_pipeline
// Description : Single-clock sample sequencer between the ADC interface, the
//               combinational IIR stage and the PWM DAC. Edge-detects ADC
//               conversions, keeps the x[n], x[n-1], y[n-1] history, waits a
//               fixed settle window for the filter, then queues the filter
//               result in a FIFO drained on rising edges of pwm_ready.
//               Optional macro SAMPLE_PIPELINE_STATS_EN adds saturating
//               drop/overflow/underflow counters (drop_cnt, ovf_cnt, unf_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module sample_pipeline
  import audio_pkg::*;
#(
  parameter int N      = AUDIO_N,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N-1:0]               adc_data,
  input  logic                       adc_valid,
  output logic [N-1:0]               x_cur,
  output logic [N-1:0]               x_prev,
  output logic [N-1:0]               y_prev,
  input  logic [N-1:0]               filt_out,
  input  logic                       pwm_ready,
  output logic [N-1:0]               duty_val,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
`ifdef SAMPLE_PIPELINE_STATS_EN
  ,
  output logic [15:0]                drop_cnt,
  output logic [15:0]                ovf_cnt,
  output logic [15:0]                unf_cnt
`endif
);

  localparam int c_cw = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int c_lw = $clog2(DEPTH + 1);
  localparam logic [N-1:0]    c_mid      = N'(midscale(N));
  localparam logic [c_cw-1:0] c_cnt_init = c_cw'(SETTLE - 1);

  logic            valid_q;
  logic            ready_q;
  sp_state_t       state_q;
  logic [c_cw-1:0] cnt_q;
  logic [N-1:0]    x_cur_q;
  logic [N-1:0]    x_prev_q;
  logic [N-1:0]    y_prev_q;
  logic [N-1:0]    duty_q;

  logic            w_rise;
  logic            w_pop_req;
  logic            w_push;
  logic            w_wr;
  logic            w_rd;
  logic            w_full;
  logic            w_empty;
  logic [N-1:0]    w_head;
  logic [c_lw-1:0] w_level;

  assign w_rise    = adc_valid & ~valid_q;
  assign w_pop_req = pwm_ready & ~ready_q;
  assign w_push    = (state_q == SP_WRITE);
  // Reads only from a non-empty FIFO; a write while full needs a concurrent read
  assign w_rd      = w_pop_req & ~w_empty;
  assign w_wr      = w_push & (~w_full | w_rd);

  // Delayed copies of the strobe levels for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      valid_q <= adc_valid;
      ready_q <= pwm_ready;
    end
  end

  // Sequencer: capture a sample, hold it for the settle window, commit the filter result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SP_IDLE;
      cnt_q    <= '0;
      x_cur_q  <= c_mid;
      x_prev_q <= c_mid;
      y_prev_q <= c_mid;
    end else begin
      case (state_q)
        SP_IDLE: begin
          if (w_rise) begin
            x_prev_q <= x_cur_q;
            x_cur_q  <= adc_data;
            cnt_q    <= c_cnt_init;
            state_q  <= SP_SETTLE;
          end
        end
        SP_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= SP_WRITE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SP_WRITE: begin
          // Feedback follows the filter even when the FIFO discards the sample
          y_prev_q <= filt_out;
          state_q  <= SP_IDLE;
        end
        default: begin
          state_q <= SP_IDLE;
        end
      endcase
    end
  end

  // Duty register loads the FIFO head on each successful pop, otherwise holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q <= c_mid;
    end else if (w_rd) begin
      duty_q <= w_head;
    end
  end

  sample_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (w_wr),
    .rd_i    (w_rd),
    .wdata_i (filt_out),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  assign x_cur      = x_cur_q;
  assign x_prev     = x_prev_q;
  assign y_prev     = y_prev_q;
  assign duty_val   = duty_q;
  assign fifo_level = w_level;

`ifdef SAMPLE_PIPELINE_STATS_EN
  logic        w_drop;
  logic        w_ovf;
  logic        w_unf;
  logic [15:0] drop_cnt_q;
  logic [15:0] ovf_cnt_q;
  logic [15:0] unf_cnt_q;

  assign w_drop = w_rise & (state_q != SP_IDLE);
  assign w_ovf  = w_push & w_full & ~w_rd;
  assign w_unf  = w_pop_req & w_empty;

  // Event counters, each saturating at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      ovf_cnt_q  <= '0;
      unf_cnt_q  <= '0;
    end else begin
      if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      if (w_ovf && (ovf_cnt_q != 16'hFFFF)) begin
        ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
      if (w_unf && (unf_cnt_q != 16'hFFFF)) begin
        unf_cnt_q <= unf_cnt_q + 16'd1;
      end
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;
  assign unf_cnt  = unf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_pipeline
// Description : Directed, table-driven bench for sample_pipeline with
//               hand-written sequences for drop, full/empty push-pop and
//               mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_pipeline;

  localparam int N      = 10;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 3;
  localparam int LW     = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_IDLE   = 2'd0;
  localparam logic [1:0] OP_SAMPLE = 2'd1;
  localparam logic [1:0] OP_POP    = 2'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  adc_data;
  logic          adc_valid;
  logic [N-1:0]  x_cur;
  logic [N-1:0]  x_prev;
  logic [N-1:0]  y_prev;
  logic [N-1:0]  filt_out;
  logic          pwm_ready;
  logic [N-1:0]  duty_val;
  logic [LW-1:0] fifo_level;
`ifdef SAMPLE_PIPELINE_STATS_EN
  logic [15:0]   drop_cnt;
  logic [15:0]   ovf_cnt;
  logic [15:0]   unf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_pipeline #(
    .N      (N),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .x_cur      (x_cur),
    .x_prev     (x_prev),
    .y_prev     (y_prev),
    .filt_out   (filt_out),
    .pwm_ready  (pwm_ready),
    .duty_val   (duty_val),
    .fifo_level (fifo_level)
`ifdef SAMPLE_PIPELINE_STATS_EN
    ,
    .drop_cnt   (drop_cnt),
    .ovf_cnt    (ovf_cnt),
    .unf_cnt    (unf_cnt)
`endif
  );

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] data;
    logic [N-1:0] filt;
    logic [N-1:0] xc;
    logic [N-1:0] xp;
    logic [N-1:0] yp;
    logic [N-1:0] duty;
    int           lvl;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [N-1:0] xc, input logic [N-1:0] xp,
                          input logic [N-1:0] yp, input logic [N-1:0] duty, input int lvl);
    chk({tag, ".x_cur"},      32'(x_cur),      32'(xc));
    chk({tag, ".x_prev"},     32'(x_prev),     32'(xp));
    chk({tag, ".y_prev"},     32'(y_prev),     32'(yp));
    chk({tag, ".duty_val"},   32'(duty_val),   32'(duty));
    chk({tag, ".fifo_level"}, 32'(fifo_level), 32'(lvl));
  endtask

  // Advance one clock; callers resume 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One ADC conversion through the whole settle window; optional pop at the write edge
  task automatic do_sample(input logic [N-1:0] d, input logic [N-1:0] f, input bit pop_w);
    adc_data  = d;
    filt_out  = f;
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    repeat (SETTLE) step();
    if (pop_w) pwm_ready = 1'b1;
    step();
    if (pop_w) begin
      pwm_ready = 1'b0;
      step();
    end
  endtask

  task automatic do_pop();
    pwm_ready = 1'b1;
    step();
    pwm_ready = 1'b0;
    step();
  endtask

  initial begin
    logic [N-1:0] exp_pop [4];

    //            op         data    filt    x_cur   x_prev  y_prev  duty    lvl
    tbl[0]  = '{OP_IDLE,   10'h3FF, 10'h155, 10'h200, 10'h200, 10'h200, 10'h200, 0};
    tbl[1]  = '{OP_SAMPLE, 10'h100, 10'h155, 10'h100, 10'h200, 10'h155, 10'h200, 1};
    tbl[2]  = '{OP_POP,    10'h000, 10'h000, 10'h100, 10'h200, 10'h155, 10'h155, 0};
    tbl[3]  = '{OP_POP,    10'h000, 10'h000, 10'h100, 10'h200, 10'h155, 10'h155, 0};
    tbl[4]  = '{OP_SAMPLE, 10'h011, 10'h0A1, 10'h011, 10'h100, 10'h0A1, 10'h155, 1};
    tbl[5]  = '{OP_SAMPLE, 10'h022, 10'h0B2, 10'h022, 10'h011, 10'h0B2, 10'h155, 2};
    tbl[6]  = '{OP_SAMPLE, 10'h033, 10'h0C3, 10'h033, 10'h022, 10'h0C3, 10'h155, 3};
    tbl[7]  = '{OP_SAMPLE, 10'h044, 10'h0D4, 10'h044, 10'h033, 10'h0D4, 10'h155, 4};
    tbl[8]  = '{OP_SAMPLE, 10'h055, 10'h0E5, 10'h055, 10'h044, 10'h0E5, 10'h155, 4};
    tbl[9]  = '{OP_POP,    10'h000, 10'h000, 10'h055, 10'h044, 10'h0E5, 10'h0A1, 3};
    tbl[10] = '{OP_POP,    10'h000, 10'h000, 10'h055, 10'h044, 10'h0E5, 10'h0B2, 2};
    tbl[11] = '{OP_POP,    10'h000, 10'h000, 10'h055, 10'h044, 10'h0E5, 10'h0C3, 1};
    tbl[12] = '{OP_POP,    10'h000, 10'h000, 10'h055, 10'h044, 10'h0E5, 10'h0D4, 0};
    tbl[13] = '{OP_POP,    10'h000, 10'h000, 10'h055, 10'h044, 10'h0E5, 10'h0D4, 0};

    // Reset with a full-scale ADC word on the bus
    reset     = 1'b1;
    adc_data  = 10'h3FF;
    adc_valid = 1'b0;
    filt_out  = 10'h155;
    pwm_ready = 1'b0;
    repeat (2) step();
    chk_outs("reset", 10'h200, 10'h200, 10'h200, 10'h200, 0);
    reset = 1'b0;

    // Table: idle, first sample and pop, underflow, fill past full, drain in order
    for (int i = 0; i < 14; i++) begin
      case (tbl[i].op)
        OP_SAMPLE: do_sample(tbl[i].data, tbl[i].filt, 1'b0);
        OP_POP:    do_pop();
        default:   step();
      endcase
      chk_outs($sformatf("row%0d", i), tbl[i].xc, tbl[i].xp, tbl[i].yp, tbl[i].duty, tbl[i].lvl);
    end

    // Rise during SETTLE is dropped; capture timing and write edge checked cycle by cycle
    adc_data  = 10'h1AA;
    filt_out  = 10'h1BB;
    adc_valid = 1'b1;
    step();
    chk("drop.e0.x_cur", 32'(x_cur), 32'h1AA);
    chk("drop.e0.x_prev", 32'(x_prev), 32'h055);
    adc_valid = 1'b0;
    step();
    adc_data  = 10'h2CC;
    adc_valid = 1'b1;
    step();
    chk("drop.e2.x_cur", 32'(x_cur), 32'h1AA);
    chk("drop.e2.x_prev", 32'(x_prev), 32'h055);
    adc_valid = 1'b0;
    step();
    chk("drop.e3.y_prev", 32'(y_prev), 32'h0E5);
    chk("drop.e3.level", 32'(fifo_level), 32'd0);
    step();
    chk_outs("drop.e4", 10'h1AA, 10'h055, 10'h1BB, 10'h0D4, 1);

    // Fill to full, then push with a concurrent pop: succeeds, level stays at DEPTH
    do_sample(10'h301, 10'h311, 1'b0);
    do_sample(10'h302, 10'h312, 1'b0);
    do_sample(10'h303, 10'h313, 1'b0);
    chk("full.level", 32'(fifo_level), 32'd4);
    do_sample(10'h304, 10'h314, 1'b1);
    chk_outs("fullpp", 10'h304, 10'h303, 10'h314, 10'h1BB, 4);
    exp_pop[0] = 10'h311;
    exp_pop[1] = 10'h312;
    exp_pop[2] = 10'h313;
    exp_pop[3] = 10'h314;
    for (int k = 0; k < 4; k++) begin
      do_pop();
      chk($sformatf("drain%0d.duty", k), 32'(duty_val), 32'(exp_pop[k]));
      chk($sformatf("drain%0d.level", k), 32'(fifo_level), 32'(3 - k));
    end

    // Push and pop together on an empty FIFO: pop underflows, push lands
    do_sample(10'h0AA, 10'h0BB, 1'b1);
    chk_outs("emptypp", 10'h0AA, 10'h304, 10'h0BB, 10'h314, 1);
    do_pop();
    chk("emptypp.pop.duty", 32'(duty_val), 32'h0BB);
    chk("emptypp.pop.level", 32'(fifo_level), 32'd0);

`ifdef SAMPLE_PIPELINE_STATS_EN
    chk("stats.drop", 32'(drop_cnt), 32'd1);
    chk("stats.ovf", 32'(ovf_cnt), 32'd1);
    chk("stats.unf", 32'(unf_cnt), 32'd3);
`endif

    // Reset asserted during SETTLE with two entries queued
    do_sample(10'h123, 10'h1C1, 1'b0);
    do_sample(10'h124, 10'h1C2, 1'b0);
    chk("pre_rst.level", 32'(fifo_level), 32'd2);
    adc_data  = 10'h125;
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk_outs("midrst", 10'h200, 10'h200, 10'h200, 10'h200, 0);
`ifdef SAMPLE_PIPELINE_STATS_EN
    chk("midrst.drop", 32'(drop_cnt), 32'd0);
    chk("midrst.unf", 32'(unf_cnt), 32'd0);
`endif
    repeat (2) step();
    reset = 1'b0;
    step();
    do_sample(10'h0F0, 10'h0F1, 1'b0);
    chk_outs("postrst", 10'h0F0, 10'h200, 10'h0F1, 10'h200, 1);
    do_pop();
    chk("postrst.pop.duty", 32'(duty_val), 32'h0F1);
    chk("postrst.pop.level", 32'(fifo_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_pipeline.md
# sample_pipeline

Single-clock sample sequencer between the audio ADC interface, the `diffEq` IIR stage and the `pwm_audio` DAC. It edge-detects ADC conversions and maintains the x[n], x[n-1] and y[n-1] history registers. It gives the combinational filter a fixed settle window, then buffers filter results in a small FIFO that the PWM drains on its ready strobe. It replaces the per-signal `posedge valid` registers with one synchronous pipeline. The y[n-1] feedback is the previous filter output, not the previously played duty value.

## Interface
- `N`, 10, sample width in bits (ADC, filter, DAC)
- `DEPTH`, 4, FIFO entries, power of two, ≥2
- `SETTLE`, 3, cycles the filter output settles after x registers update (≥1)

- `clk` in 1: system clock; all inputs synchronous to it
- `reset` in 1: asynchronous, active-high; one clock, reset asynchronous active-high
- `adc_data` in N: ADC conversion word
- `adc_valid` in 1: ADC valid level; a new sample is marked by its rising edge
- `x_cur` out N: x[n] to filter
- `x_prev` out N: x[n-1] to filter
- `y_prev` out N: y[n-1] feedback to filter
- `filt_out` in N: filter output (combinational from x_cur/x_prev/y_prev)
- `pwm_ready` in 1: PWM ready level; a sample is consumed on its rising edge
- `duty_val` out N: current PWM duty
- `fifo_level` out $clog2(DEPTH+1): FIFO occupancy

## Operation
- MID = 2^(N-1). Reset values: `x_cur`, `x_prev`, `y_prev`, `duty_val` = MID; `fifo_level` = 0; `valid_d`/`ready_d` = 0; FSM in IDLE; FIFO empty.
- Edge detect: `rise = adc_valid & ~valid_d`, `pop_req = pwm_ready & ~ready_d`. `valid_d` and `ready_d` are registered every cycle.
- FSM states and transitions:
  - IDLE: on `rise`, `x_prev<=x_cur`, `x_cur<=adc_data`, cnt<=SETTLE-1, go to SETTLE.
  - SETTLE: cnt decrements each cycle. The edge with cnt==0 goes to WRITE.
  - WRITE: push `filt_out` into FIFO, `y_prev<=filt_out`, go to IDLE.
- A `rise` outside IDLE drops that sample. The x registers are unchanged.
- Pop: on `pop_req` with FIFO non-empty, `duty_val<=head` and the head is removed. If empty, this is an underflow: `duty_val` holds its last value.
- Push while full with no simultaneous pop is an overflow: the new sample is discarded and `y_prev` is still updated. Push while full with a simultaneous pop succeeds and the level is unchanged.
- Simultaneous push and pop when empty: the pop underflows, the push lands, and the level becomes 1. There is no bypass.
- Pointers are log2(DEPTH) bits and wrap naturally. `fifo_level` is an explicit counter (+1 push, −1 pop, 0 both).
- All data is unsigned N-bit, passed through unmodified. There is no arithmetic on samples.

## Timing
- Capture edge E0: x registers update.
- Filter path is multicycle: `filt_out` is sampled at E0+SETTLE+1.
- At that same edge the FIFO is written, `y_prev` updates and the FSM returns to IDLE.
- Minimum accepted sample spacing is SETTLE+2 cycles between `adc_valid` rising edges.
- Pop latency: `duty_val` updates on the edge where `pop_req` is true, one cycle after `pwm_ready` is first seen high.
- Reset asserted mid-operation returns everything to reset values immediately. FIFO contents are discarded.

## Configuration
- `SAMPLE_PIPELINE_STATS_EN` defined:
  - Adds outputs `drop_cnt`, `ovf_cnt` and `unf_cnt`, each 16 bits, reset 0.
  - Each saturates at 16'hFFFF.
  - Incremented on dropped rise, overflow and underflow respectively.
- Not defined: these ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package `audio_pkg`:
  - `sp_state_t` enum (IDLE, SETTLE, WRITE)
  - default `AUDIO_N` = 10
  - function `midscale(N)`
- One sub-module `sample_fifo` (DEPTH×N, push/pop/full/empty/level, async active-high reset).
- FSM, edge detection, history registers and stats live in `sample_pipeline`.

## Test plan
- Reset with `adc_data`=10'h3FF held: all outputs are 10'h200 and `fifo_level`=0. Deassert reset, no strobes: outputs unchanged.
- Pulse `adc_valid` with `adc_data`=10'h100, `filt_out` tied to 10'h155:
  - `x_cur`=0x100 and `x_prev`=0x200 one cycle after the rise.
  - `y_prev`=0x155 and `fifo_level`=1 at E0+4.
  - Then a `pwm_ready` rise gives `duty_val`=0x155 and `fifo_level`=0.
- Five samples without pops: `fifo_level` saturates at 4. The fifth is discarded (`ovf_cnt`=1 with STATS_EN). Pops return the first four in order.
- `pwm_ready` rise with FIFO empty: `duty_val` holds its prior value and `unf_cnt` increments.
- Second `adc_valid` rise two cycles after the first: it is dropped, `x_cur` keeps the first sample and `drop_cnt`=1.
- Assert `reset` during SETTLE with 2 entries queued: outputs return to 0x200 and `fifo_level`=0 within the same cycle. The next sample then proceeds normally.
